beam_serializer: RTL and testbench

Transmit-side counterpart of the 4-block beam collector. It accepts 64-channel wide beam vectors, one address per cycle, and stores each frame in a ping-pong RAM. It then replays the frame as four sequential 16-channel bursts (channels 0–15, 16–31, 32–47, 48–63), each framed by `o_tvalid` with idle gaps between bursts. The downstream collector uses the falling edge of `o_tvalid` to advance its block counter.

---
 rtl/beam_pkg.sv | 20 ++
 rtl/sdp_ram_2clk.sv | 26 ++
 rtl/beam_serializer.sv | 185 ++++++++++++++++++
 tb/tb_beam_serializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/beam_pkg.sv
// Shared constants and FSM encoding for the beam serializer: a 64-channel
// frame is replayed as four 16-channel blocks.
package beam_pkg;

  localparam int NUM_BLOCKS   = 4;
  localparam int CH_PER_BLOCK = 16;
  localparam int NUM_CH       = 64;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    GAP,
    DONE
  } ser_state_t;

  function automatic logic is_last_block(input logic [1:0] blk);
    return blk == 2'(NUM_BLOCKS - 1);
  endfunction

endpackage

// File: rtl/sdp_ram_2clk.sv
// Simple dual-port RAM with a two-stage registered read path; the MSB of
// each address selects the ping-pong bank.
module sdp_ram_2clk #(
  parameter int WIDTH = 2560,
  parameter int AW    = 12
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
  logic [WIDTH-1:0] rd_stage_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rd_stage_q <= mem_q[raddr_i];
    rdata_o    <= rd_stage_q;
  end

endmodule

// File: rtl/beam_serializer.sv
// Ping-pong frame buffer that stores 64-channel beam vectors and replays each
// frame as four 16-channel bursts separated by idle gaps.
module beam_serializer
  import beam_pkg::*;
#(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 11,
  parameter int GAP_CYCLES = 4
) (
  input  logic                                      i_clk,
  input  logic                                      i_reset,
  input  logic                                      i_wr_vld,
  input  logic [ADDR_WIDTH-1:0]                     i_wr_addr,
  input  logic                                      i_wr_last,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]         i_wr_data,
  output logic                                      o_tvalid,
  output logic                                      o_rd_vld,
  output logic [ADDR_WIDTH-1:0]                     o_rd_addr,
  output logic [CH_PER_BLOCK-1:0][DATA_WIDTH-1:0]   o_rd_data,
  output logic [1:0]                                o_blk_idx,
  output logic                                      o_busy,
  output logic                                      o_overflow
);

  localparam int WORD_W  = NUM_CH * DATA_WIDTH;
  localparam int SLICE_W = CH_PER_BLOCK * DATA_WIDTH;
  // GAP runs for counts 0..GAP_CYCLES; with the BURST re-entry cycle this
  // yields GAP_CYCLES+1 low cycles on o_tvalid between blocks.
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES);

  logic                  wr_bank_q, wr_bank_d;
  logic [1:0]            full_q, full_d;
  logic [ADDR_WIDTH-1:0] last_addr_q [2];
  logic                  overflow_q;
  logic                  wr_accept, wr_drop, frame_end;

  ser_state_t            state_q, state_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [1:0]            blk_q, blk_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [3:0]            gap_q, gap_d;
  logic                  rd_issue;

  logic                  vld_p1_q, vld_p2_q;
  logic [ADDR_WIDTH-1:0] addr_p1_q, addr_p2_q;
  logic [1:0]            blk_p1_q, blk_p2_q;
  logic [WORD_W-1:0]     ram_rdata;
  logic [SLICE_W-1:0]    slice;

  assign wr_accept = i_wr_vld && !full_q[wr_bank_q];
  assign wr_drop   = i_wr_vld && full_q[wr_bank_q];
  assign frame_end = wr_accept && i_wr_last;
  assign rd_issue  = (state_q == BURST);

  // A new frame's set takes priority over the DONE clear on the same bank.
  always_comb begin
    wr_bank_d = wr_bank_q ^ frame_end;
    full_d    = full_q;
    if (state_q == DONE) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (frame_end) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_bank_q      <= 1'b0;
      full_q         <= '0;
      overflow_q     <= 1'b0;
      last_addr_q[0] <= '0;
      last_addr_q[1] <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      full_q     <= full_d;
      overflow_q <= wr_drop;
      if (frame_end) begin
        last_addr_q[wr_bank_q] <= i_wr_addr;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    blk_d     = blk_q;
    raddr_d   = raddr_q;
    gap_d     = gap_q;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = BURST;
          blk_d   = 2'd0;
          raddr_d = '0;
        end
      end
      BURST: begin
        if (raddr_q == last_addr_q[rd_bank_q]) begin
          gap_d   = 4'd0;
          state_d = is_last_block(blk_q) ? DONE : GAP;
        end else begin
          raddr_d = raddr_q + ADDR_WIDTH'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = BURST;
          blk_d   = blk_q + 2'd1;
          raddr_d = '0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      DONE: begin
        rd_bank_d = ~rd_bank_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      blk_q     <= 2'd0;
      raddr_q   <= '0;
      gap_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      blk_q     <= blk_d;
      raddr_q   <= raddr_d;
      gap_q     <= gap_d;
    end
  end

  sdp_ram_2clk #(
    .WIDTH (WORD_W),
    .AW    (ADDR_WIDTH + 1)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (wr_accept),
    .waddr_i ({wr_bank_q, i_wr_addr}),
    .wdata_i (i_wr_data),
    .raddr_i ({rd_bank_q, raddr_q}),
    .rdata_o (ram_rdata)
  );

  // Sideband travels with the two-cycle RAM latency and is zero when idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      addr_p1_q <= '0;
      addr_p2_q <= '0;
      blk_p1_q  <= 2'd0;
      blk_p2_q  <= 2'd0;
    end else begin
      vld_p1_q  <= rd_issue;
      vld_p2_q  <= vld_p1_q;
      addr_p1_q <= rd_issue ? raddr_q : '0;
      addr_p2_q <= addr_p1_q;
      blk_p1_q  <= rd_issue ? blk_q : 2'd0;
      blk_p2_q  <= blk_p1_q;
    end
  end

  always_comb begin
    slice = '0;
    if (vld_p2_q) begin
      slice = ram_rdata[SLICE_W*int'(blk_p2_q) +: SLICE_W];
    end
  end

  assign o_rd_data  = slice;
  assign o_tvalid   = vld_p2_q;
  assign o_rd_vld   = vld_p2_q;
  assign o_rd_addr  = addr_p2_q;
  assign o_blk_idx  = blk_p2_q;
  assign o_busy     = (|full_q) || (state_q != IDLE);
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_beam_serializer.sv
// Directed bench for beam_serializer: frames tagged per test are written and
// every output cycle of their readout is compared with a computed pattern.
module tb_beam_serializer;

  localparam int DW  = 40;
  localparam int AW  = 11;
  localparam int GAP = 4;

  typedef logic [1023:0] wide_t;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   wrVld;
  logic [AW-1:0]          wrAddr;
  logic                   wrLast;
  logic [63:0][DW-1:0]    wrData;
  logic                   tvalid;
  logic                   rdVld;
  logic [AW-1:0]          rdAddr;
  logic [15:0][DW-1:0]    rdData;
  logic [1:0]             blkIdx;
  logic                   busy;
  logic                   overflow;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clock = ~clock;

  beam_serializer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .GAP_CYCLES (GAP)
  ) dut (
    .i_clk      (clock),
    .i_reset    (reset),
    .i_wr_vld   (wrVld),
    .i_wr_addr  (wrAddr),
    .i_wr_last  (wrLast),
    .i_wr_data  (wrData),
    .o_tvalid   (tvalid),
    .o_rd_vld   (rdVld),
    .o_rd_addr  (rdAddr),
    .o_rd_data  (rdData),
    .o_blk_idx  (blkIdx),
    .o_busy     (busy),
    .o_overflow (overflow)
  );

  // Channel c of word a in frame "tag" carries {tag, a, c}.
  function automatic logic [DW-1:0] patWord(input int tag, input int a, input int c);
    logic [DW-1:0] w;
    w = {tag[7:0], a[15:0], c[15:0]};
    return w;
  endfunction

  function automatic logic [15:0][DW-1:0] expSlice(input int tag, input int a, input int k);
    logic [15:0][DW-1:0] s;
    for (int j = 0; j < 16; j++) begin
      s[j] = patWord(tag, a, 16 * k + j);
    end
    return s;
  endfunction

  task automatic checkOutput(input string tag, input wide_t obs, input wide_t exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Writes one frame of len words; drops counts o_overflow pulses seen.
  task automatic applyStimulus(input int tag, input int len, output int drops);
    drops = 0;
    for (int a = 0; a < len; a++) begin
      @(negedge clock);
      if (overflow === 1'b1) drops++;
      wrVld  = 1'b1;
      wrAddr = AW'(a);
      wrLast = (a == len - 1);
      for (int c = 0; c < 64; c++) begin
        wrData[c] = patWord(tag, a, c);
      end
    end
    @(negedge clock);
    if (overflow === 1'b1) drops++;
    wrVld  = 1'b0;
    wrLast = 1'b0;
  endtask

  task automatic waitStart(input int maxWait, input int expDelay, output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (tvalid !== 1'b1 && n < maxWait);
    if (tvalid !== 1'b1) begin
      checkOutput("start timeout", wide_t'(tvalid), wide_t'(1));
      ok = 1'b0;
    end else begin
      ok = 1'b1;
      if (expDelay >= 0) checkOutput("start latency", wide_t'(n), wide_t'(expDelay));
    end
  endtask

  task automatic expectFrame(input int tag, input int len, input int delay);
    bit ok;
    waitStart(200, delay, ok);
    if (!ok) return;
    for (int k = 0; k < 4; k++) begin
      for (int a = 0; a < len; a++) begin
        checkOutput("burst ctl", wide_t'({tvalid, rdVld, blkIdx, rdAddr}),
                    wide_t'({1'b1, 1'b1, 2'(k), AW'(a)}));
        checkOutput("burst data", wide_t'(rdData), wide_t'(expSlice(tag, a, k)));
        if (!(k == 3 && a == len - 1)) @(negedge clock);
      end
      if (k < 3) begin
        for (int g = 0; g <= GAP; g++) begin
          checkOutput("gap low", wide_t'(tvalid), wide_t'(0));
          @(negedge clock);
        end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int drops;
    int dropsB;
    int dropsE;
    int cnt;
    bit ok;

    reset  = 1'b1;
    wrVld  = 1'b0;
    wrAddr = '0;
    wrLast = 1'b0;
    wrData = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset ctl", wide_t'({tvalid, rdVld, rdAddr, blkIdx, busy, overflow}), wide_t'(0));
    checkOutput("reset data", wide_t'(rdData), wide_t'(0));
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] frame L=8");
    applyStimulus(1, 8, drops);
    checkOutput("busy after write", wide_t'(busy), wide_t'(1));
    checkOutput("drops L=8", wide_t'(drops), wide_t'(0));
    // last write edge ends the call's final-1 cycle: tvalid is high 3 negedges later
    expectFrame(1, 8, 3);
    repeat (3) @(negedge clock);
    checkOutput("busy idle", wide_t'(busy), wide_t'(0));

    $display("[TB] frame L=1");
    applyStimulus(2, 1, drops);
    expectFrame(2, 1, 3);
    repeat (3) @(negedge clock);

    $display("[TB] frame L=2048");
    applyStimulus(3, 2048, drops);
    checkOutput("drops L=2048", wide_t'(drops), wide_t'(0));
    expectFrame(3, 2048, 3);
    repeat (3) @(negedge clock);

    $display("[TB] back-to-back frames");
    applyStimulus(4, 16, drops);
    fork
      expectFrame(4, 16, 3);
      begin
        repeat (20) @(negedge clock);
        applyStimulus(5, 4, dropsB);
      end
    join
    checkOutput("drops B", wide_t'(dropsB), wide_t'(0));
    expectFrame(5, 4, 3);
    repeat (3) @(negedge clock);

    $display("[TB] overflow on third frame");
    applyStimulus(6, 8, drops);
    fork
      expectFrame(6, 8, 3);
      begin
        applyStimulus(7, 8, dropsB);
        applyStimulus(8, 4, dropsE);
      end
    join
    checkOutput("drops second", wide_t'(dropsB), wide_t'(0));
    checkOutput("drops third", wide_t'(dropsE), wide_t'(4));
    expectFrame(7, 8, 3);
    cnt = 0;
    repeat (120) begin
      @(negedge clock);
      if (tvalid === 1'b1) cnt++;
    end
    checkOutput("no third frame", wide_t'(cnt), wide_t'(0));
    checkOutput("busy after drop", wide_t'(busy), wide_t'(0));

    $display("[TB] reset during block 2");
    applyStimulus(9, 8, drops);
    waitStart(200, 3, ok);
    cnt = 0;
    while (!(tvalid === 1'b1 && blkIdx === 2'd2) && cnt < 300) begin
      @(negedge clock);
      cnt++;
    end
    checkOutput("reach block 2", wide_t'({tvalid, blkIdx}), wide_t'({1'b1, 2'd2}));
    reset = 1'b1;
    @(negedge clock);
    checkOutput("mid reset ctl", wide_t'({tvalid, rdVld, rdAddr, blkIdx, busy}), wide_t'(0));
    checkOutput("mid reset data", wide_t'(rdData), wide_t'(0));
    reset = 1'b0;
    repeat (20) @(negedge clock);
    checkOutput("no resume", wide_t'({tvalid, busy}), wide_t'(0));
    applyStimulus(10, 4, drops);
    expectFrame(10, 4, 3);
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
